// File: rtl/dmem_responder_if.sv
// dmem_responder_if: LSU load/store port between the LSU (master) and dmem_responder (slave).
// par_inject exists only when DMEM_PARITY_EN is defined.
interface dmem_responder_if;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] rd_addr;
    logic        rd_en;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        busy;
    logic        addr_err;
`ifdef DMEM_PARITY_EN
    logic        par_inject;
    modport master (output wr_addr, wr_data, wr_en, rd_addr, rd_en, par_inject,
                    input data_out, rd_valid, busy, addr_err);
    modport slave  (input wr_addr, wr_data, wr_en, rd_addr, rd_en, par_inject,
                    output data_out, rd_valid, busy, addr_err);
`else
    modport master (output wr_addr, wr_data, wr_en, rd_addr, rd_en,
                    input data_out, rd_valid, busy, addr_err);
    modport slave  (input wr_addr, wr_data, wr_en, rd_addr, rd_en,
                    output data_out, rd_valid, busy, addr_err);
`endif
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: LSU-facing data memory with fixed-latency loads, address checking and optional parity
module dmem_responder #(
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 2,
  parameter     INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
`ifdef DMEM_PARITY_EN
  localparam int W = 33;
`else
  localparam int W = 32;
`endif
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [0:0] IDLE = 1'b0, WAIT = 1'b1;
  logic [W-1:0]        mem [DEPTH];
  logic [0:0]          state;
  logic [3:0]          cnt;
  logic [IW-1:0]       idx;
  logic [READ_LAT-1:0] pend;
  logic                wr_good, rd_good, wr_acc, rd_acc, done, par_bad;
  logic [W-1:0]        word, wdata;
  logic [31:0]         resp;
  assign bus.busy = state == WAIT;
  assign wr_good  = bus.wr_addr[1:0] == 2'b0 && {2'b0, bus.wr_addr[31:2]} < 32'(DEPTH);
  assign rd_good  = bus.rd_addr[1:0] == 2'b0 && {2'b0, bus.rd_addr[31:2]} < 32'(DEPTH);
  assign wr_acc   = bus.wr_en && !bus.busy;
  assign rd_acc   = bus.rd_en && !bus.busy;
  assign done     = state == WAIT && cnt == 4'd0;
  assign word     = mem[idx];
`ifdef DMEM_PARITY_EN
  assign wdata    = {^bus.wr_data ^ bus.par_inject, bus.wr_data};
  assign par_bad  = ^word[31:0] != word[32];
  assign resp     = par_bad ? 32'hDEAD_BEEF : word[31:0];
`else
  assign wdata    = bus.wr_data;
  assign par_bad  = 1'b0;
  assign resp     = word;
`endif
  always_ff @(posedge clk)
    if (rst && wr_acc && wr_good) mem[bus.wr_addr[IW+1:2]] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      idx          <= '0;
      pend         <= '0;
      bus.data_out <= 32'h0;
      bus.rd_valid <= 1'b0;
      bus.addr_err <= 1'b0;
    end else begin
      pend         <= READ_LAT'({pend, rd_acc && !rd_good});
      bus.rd_valid <= done || pend[READ_LAT-1];
      bus.addr_err <= (wr_acc && !wr_good) || (rd_acc && !rd_good) || (done && par_bad);
      bus.data_out <= done ? resp : pend[READ_LAT-1] ? 32'h0 : bus.data_out;
      if (rd_acc && rd_good) begin
        state <= WAIT;
        cnt   <= 4'(READ_LAT - 1);
        idx   <= bus.rd_addr[IW+1:2];
      end else if (done) state <= IDLE;
      else if (state == WAIT) cnt <= cnt - 4'd1;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (DEPTH=1024, READ_LAT=2).
// Parity scenario is compiled in only when DMEM_PARITY_EN is defined.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    dmem_responder_if b ();
    dmem_responder #(.DEPTH(DEPTH), .READ_LAT(2), .INIT_FILE("")) dut (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        b.wr_addr = a;
        b.wr_data = d;
        b.wr_en   = 1'b1;
        tick;
        b.wr_en   = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d, output logic got);
        b.rd_addr = a;
        b.rd_en   = 1'b1;
        tick;
        b.rd_en   = 1'b0;
        got = 1'b0;
        d   = 32'hx;
        for (int i = 0; i < 20 && !got; i++)
            if (b.rd_valid) begin
                got = 1'b1;
                d   = b.data_out;
            end else tick;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        b.rd_en = 1'b1;
        b.rd_addr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++;
            if ({b.data_out, b.rd_valid, b.busy, b.addr_err} !== 35'h0) begin
                fails++;
                $display("FAIL reset cyc%0d: data_out=%h rd_valid=%b busy=%b addr_err=%b, want all 0",
                         i, b.data_out, b.rd_valid, b.busy, b.addr_err);
            end
        end
        b.rd_en = 1'b0;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_store_load;
        store(32'h10, 32'hCAFE_F00D);
        b.rd_addr = 32'h10;
        b.rd_en = 1'b1;
        tick;
        b.rd_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tests++;
            if ({b.busy, b.rd_valid} !== (i < 3 ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL store_load cyc%0d: busy=%b rd_valid=%b want busy=%b rd_valid=%b",
                         i, b.busy, b.rd_valid, i < 3, i == 3);
            end
            if (i < 3) tick;
        end
        tests++;
        if (b.data_out !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL store_load data: got %h want cafef00d", b.data_out);
        end
        tick;
        tests++;
        if (b.rd_valid !== 1'b0 || b.data_out !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL store_load hold: rd_valid=%b data_out=%h want 0/cafef00d", b.rd_valid, b.data_out);
        end
    endtask

    task automatic test_same_edge;
        int pulses = 0;
        logic [31:0] d;
        logic got;
        b.wr_addr = 32'h20;
        b.wr_data = 32'h1234_5678;
        b.rd_addr = 32'h20;
        b.wr_en = 1'b1;
        b.rd_en = 1'b1;
        tick;
        b.wr_data = 32'hFFFF_FFFF;
        b.rd_addr = 32'h10;
        for (int i = 0; i < 6; i++) begin
            if (b.rd_valid) begin
                pulses++;
                tests++;
                if (b.data_out !== 32'h1234_5678) begin
                    fails++;
                    $display("FAIL same_edge data: got %h want 12345678", b.data_out);
                end
            end
            tick;
            b.wr_en = 1'b0;
            b.rd_en = 1'b0;
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL same_edge pulses: got %0d want 1", pulses);
        end
        do_load(32'h20, d, got);
        tests++;
        if (!got || d !== 32'h1234_5678) begin
            fails++;
            $display("FAIL busy_store_ignored: got=%b data=%h want 1/12345678", got, d);
        end
    endtask

    task automatic test_addr_err;
        logic [31:0] d;
        logic got;
        store(32'h0, 32'h5555_AAAA);
        b.rd_addr = 32'h6;
        b.wr_addr = DEPTH * 4;
        b.wr_data = 32'h0000_0BAD;
        b.rd_en = 1'b1;
        b.wr_en = 1'b1;
        tick;
        b.rd_en = 1'b0;
        b.wr_en = 1'b0;
        tests++;
        if ({b.addr_err, b.busy, b.rd_valid} !== 3'b100) begin
            fails++;
            $display("FAIL addr_err pulse: addr_err=%b busy=%b rd_valid=%b want 1/0/0", b.addr_err, b.busy, b.rd_valid);
        end
        tick;
        tests++;
        if ({b.addr_err, b.rd_valid} !== 2'b00) begin
            fails++;
            $display("FAIL addr_err single: addr_err=%b rd_valid=%b want 0/0", b.addr_err, b.rd_valid);
        end
        tick;
        tests++;
        if (b.rd_valid !== 1'b1 || b.data_out !== 32'h0 || b.addr_err !== 1'b0) begin
            fails++;
            $display("FAIL err_response: rd_valid=%b data_out=%h addr_err=%b want 1/0/0", b.rd_valid, b.data_out, b.addr_err);
        end
        b.wr_addr = 32'h2;
        b.wr_en = 1'b1;
        tick;
        b.wr_en = 1'b0;
        tests++;
        if (b.addr_err !== 1'b1) begin
            fails++;
            $display("FAIL store_misaligned: addr_err=%b want 1", b.addr_err);
        end
        do_load(32'h0, d, got);
        tests++;
        if (!got || d !== 32'h5555_AAAA) begin
            fails++;
            $display("FAIL no_write: got=%b data=%h want 1/5555aaaa", got, d);
        end
    endtask

    task automatic test_reset_mid_load;
        int pulses = 0;
        logic [31:0] d;
        logic got;
        store(32'h40, 32'h0BAD_F00D);
        b.rd_addr = 32'h40;
        b.rd_en = 1'b1;
        tick;
        b.rd_en = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (b.busy !== 1'b0 || b.data_out !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: busy=%b data_out=%h want 0/0", b.busy, b.data_out);
        end
        tick;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b.rd_valid) pulses++;
            tick;
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL dropped_load: rd_valid pulses=%0d want 0", pulses);
        end
        do_load(32'h40, d, got);
        tests++;
        if (!got || d !== 32'h0BAD_F00D) begin
            fails++;
            $display("FAIL reload: got=%b data=%h want 1/0badf00d", got, d);
        end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity;
        b.par_inject = 1'b1;
        store(32'h80, 32'h1);
        b.par_inject = 1'b0;
        b.rd_addr = 32'h80;
        b.rd_en = 1'b1;
        tick;
        b.rd_en = 1'b0;
        tick;
        tick;
        tests++;
        if ({b.rd_valid, b.addr_err} !== 2'b11 || b.data_out !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL parity: rd_valid=%b addr_err=%b data_out=%h want 1/1/deadbeef", b.rd_valid, b.addr_err, b.data_out);
        end
    endtask
`endif

    initial begin
        b.wr_addr = 32'h0;
        b.wr_data = 32'h0;
        b.wr_en = 1'b0;
        b.rd_addr = 32'h0;
        b.rd_en = 1'b0;
`ifdef DMEM_PARITY_EN
        b.par_inject = 1'b0;
`endif
        test_reset;
        test_store_load;
        test_same_edge;
        test_addr_err;
        test_reset_mid_load;
`ifdef DMEM_PARITY_EN
        test_parity;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
